// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch front end.
// Fetch address and word widths default to 32 bits when no platform config defines them.
`ifndef DRAM_ADDRESS_SIZE
`define DRAM_ADDRESS_SIZE 32
`endif
`ifndef DRAM_WORD_SIZE
`define DRAM_WORD_SIZE 32
`endif

package fetch_pkg;
  localparam int FETCH_ADDR_W = `DRAM_ADDRESS_SIZE;
  localparam int FETCH_WORD_W = `DRAM_WORD_SIZE;
  localparam int PC_STEP      = 4;

  typedef enum logic [1:0] {
    IDLE        = 2'd0,
    WAIT        = 2'd1,
    WAIT_SQUASH = 2'd2
  } fetch_state_t;

  typedef struct packed {
    logic [FETCH_WORD_W-1:0] instr;
    logic [FETCH_ADDR_W-1:0] pc;
  } fetch_entry_t;
endpackage

// File: rtl/fetch_queue.sv
// Prefetch FIFO of {instr, pc} entries with flush and a registered head.
// The head register is loaded with whatever entry will be oldest after this cycle's push/pop.
module fetch_queue
  import fetch_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             push,
  input  fetch_entry_t     push_entry,
  input  logic             pop,
  input  logic             flush,
  output logic [CNT_W-1:0] count,
  output logic             head_valid,
  output fetch_entry_t     head
);

  fetch_entry_t mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] rd_next;
  logic [CNT_W-1:0] remain;
  logic             do_pop;

  assign do_pop  = pop && head_valid;
  assign remain  = count - CNT_W'(do_pop);
  assign rd_next = rd_ptr + PTR_W'(do_pop);

  always_ff @(posedge clock) begin
    if (push && !flush) mem[wr_ptr] <= push_entry;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      head_valid <= 1'b0;
      head       <= '0;
    end else if (flush) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      head_valid <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      rd_ptr <= rd_next;
      count  <= remain + CNT_W'(push);
      // A push into an otherwise-empty queue bypasses the storage array.
      if (remain != '0) begin
        head       <= mem[rd_next];
        head_valid <= 1'b1;
      end else if (push) begin
        head       <= push_entry;
        head_valid <= 1'b1;
      end else begin
        head_valid <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch front end: sequential icache requests, prefetch queue, redirect flush/squash.
//   state       | meaning
//   IDLE        | no request outstanding, waiting for a free queue slot
//   WAIT        | request at icache_PC outstanding, response will be queued
//   WAIT_SQUASH | request outstanding after a redirect, response will be dropped
module instr_fetch_unit
  import fetch_pkg::*;
#(
  parameter int ADDR_W      = FETCH_ADDR_W,
  parameter int WORD_W      = FETCH_WORD_W,
  parameter int QUEUE_DEPTH = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              redirect,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic [ADDR_W-1:0] icache_PC,
  output logic              icache_instrRequest,
  input  logic [WORD_W-1:0] icache_instruction,
  input  logic              icache_instrReady,
  output logic              instr_valid,
  output logic [WORD_W-1:0] instr,
  output logic [ADDR_W-1:0] instr_pc,
  input  logic              decode_ready
);

  localparam int CNT_W = $clog2(QUEUE_DEPTH) + 1;
  localparam logic [CNT_W-1:0] FULL = CNT_W'(QUEUE_DEPTH);

  fetch_state_t      state;
  logic [ADDR_W-1:0] fetch_pc;
  logic [ADDR_W-1:0] pc_inc;
  logic [ADDR_W-1:0] redirect_base;
  logic [CNT_W-1:0]  count;
  logic [CNT_W-1:0]  count_after;
  logic              push;
  logic              pop;
  logic              head_valid;
  fetch_entry_t      push_entry;
  fetch_entry_t      head;
  logic              unused_pc_bits;

  assign redirect_base  = {redirect_pc[ADDR_W-1:2], 2'b00};
  assign unused_pc_bits = ^redirect_pc[1:0];
  assign pc_inc         = fetch_pc + ADDR_W'(PC_STEP);
  assign push           = (state == WAIT) && icache_instrReady && !redirect;
  assign pop            = head_valid && decode_ready && !redirect;
  assign push_entry     = '{instr: icache_instruction, pc: icache_PC};
  assign count_after    = count + CNT_W'(push) - CNT_W'(pop);

  fetch_queue #(.DEPTH(QUEUE_DEPTH)) u_queue (
    .clock      (clock),
    .reset      (reset),
    .push       (push),
    .push_entry (push_entry),
    .pop        (pop),
    .flush      (redirect),
    .count      (count),
    .head_valid (head_valid),
    .head       (head)
  );

  assign instr_valid = head_valid;
  assign instr       = head.instr;
  assign instr_pc    = head.pc;

  // After a redirect with nothing left in flight the queue is empty, so the
  // target request is issued straight away rather than via an idle cycle.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state               <= IDLE;
      fetch_pc            <= RESET_PC;
      icache_PC           <= RESET_PC;
      icache_instrRequest <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (redirect) begin
            state               <= WAIT;
            fetch_pc            <= redirect_base;
            icache_PC           <= redirect_base;
            icache_instrRequest <= 1'b1;
          end else if (count < FULL) begin
            state               <= WAIT;
            icache_PC           <= fetch_pc;
            icache_instrRequest <= 1'b1;
          end
        end
        WAIT: begin
          if (redirect) begin
            fetch_pc <= redirect_base;
            if (!icache_instrReady) state <= WAIT_SQUASH;
            else icache_PC <= redirect_base;
          end else if (icache_instrReady) begin
            fetch_pc <= pc_inc;
            if (count_after < FULL) begin
              icache_PC <= pc_inc;
            end else begin
              state               <= IDLE;
              icache_instrRequest <= 1'b0;
            end
          end
        end
        WAIT_SQUASH: begin
          if (redirect) fetch_pc <= redirect_base;
          if (icache_instrReady) begin
            state     <= WAIT;
            icache_PC <= redirect ? redirect_base : fetch_pc;
          end
        end
        default: begin
          state               <= IDLE;
          icache_instrRequest <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit: sequential fetch, queue fill, redirect squash,
// same-cycle redirect, PC wrap (second instance) and asynchronous reset mid-fetch.
module tb_instr_fetch_unit;

  logic        clock;
  logic        rst_n;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic [31:0] icache_PC;
  logic        icache_instrRequest;
  logic [31:0] icache_instruction;
  logic        icache_instrReady;
  logic        instr_valid;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        decode_ready;

  logic        w_redirect;
  logic [31:0] w_redirect_pc;
  logic [31:0] w_icache_PC;
  logic        w_req;
  logic [31:0] w_icache_instruction;
  logic        w_ready;
  logic        w_valid;
  logic [31:0] w_instr;
  logic [31:0] w_instr_pc;
  logic        w_decode_ready;

  int tests  = 0;
  int failed = 0;

  instr_fetch_unit dut (
    .clock               (clock),
    .reset               (rst_n),
    .redirect            (redirect),
    .redirect_pc         (redirect_pc),
    .icache_PC           (icache_PC),
    .icache_instrRequest (icache_instrRequest),
    .icache_instruction  (icache_instruction),
    .icache_instrReady   (icache_instrReady),
    .instr_valid         (instr_valid),
    .instr               (instr),
    .instr_pc            (instr_pc),
    .decode_ready        (decode_ready)
  );

  instr_fetch_unit #(.RESET_PC(32'hFFFF_FFF8)) dut_wrap (
    .clock               (clock),
    .reset               (rst_n),
    .redirect            (w_redirect),
    .redirect_pc         (w_redirect_pc),
    .icache_PC           (w_icache_PC),
    .icache_instrRequest (w_req),
    .icache_instruction  (w_icache_instruction),
    .icache_instrReady   (w_ready),
    .instr_valid         (w_valid),
    .instr               (w_instr),
    .instr_pc            (w_instr_pc),
    .decode_ready        (w_decode_ready)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clock);
  endtask

  task automatic do_reset();
    @(negedge clock);
    rst_n             = 1'b0;
    redirect          = 1'b0;
    icache_instrReady = 1'b0;
    w_ready           = 1'b0;
    @(negedge clock);
    rst_n = 1'b1;
  endtask

  // Waits (bounded) for a request, checks its address, then returns one response
  // after 'gap' extra cycles. Returns at the negedge after the ready edge.
  task automatic serve(input string tag, input logic [31:0] pc, input logic [31:0] data,
                       input int gap);
    int n = 0;
    while (icache_instrRequest !== 1'b1 && n < 20) begin
      @(negedge clock);
      n++;
    end
    check({tag, "_req"}, 64'(icache_instrRequest), 64'd1);
    check({tag, "_pc"}, 64'(icache_PC), 64'(pc));
    repeat (gap) @(negedge clock);
    icache_instruction = data;
    icache_instrReady  = 1'b1;
    @(negedge clock);
    icache_instrReady  = 1'b0;
  endtask

  logic [31:0] wrap_pc [3];

  initial begin
    rst_n                = 1'b0;
    redirect             = 1'b0;
    redirect_pc          = 32'h0;
    icache_instruction   = 32'h0;
    icache_instrReady    = 1'b0;
    decode_ready         = 1'b1;
    w_redirect           = 1'b0;
    w_redirect_pc        = 32'h0;
    w_icache_instruction = 32'h0;
    w_ready              = 1'b0;
    w_decode_ready       = 1'b1;
    wrap_pc[0] = 32'hFFFF_FFF8;
    wrap_pc[1] = 32'hFFFF_FFFC;
    wrap_pc[2] = 32'h0000_0000;

    // reset values
    step();
    step();
    check("rst_req", 64'(icache_instrRequest), 64'd0);
    check("rst_pc", 64'(icache_PC), 64'd0);
    check("rst_valid", 64'(instr_valid), 64'd0);
    check("rst_instr", 64'(instr), 64'd0);
    check("rst_instr_pc", 64'(instr_pc), 64'd0);
    rst_n = 1'b1;
    step();
    check("first_req", 64'(icache_instrRequest), 64'd1);

    // sequential fetch with decode always ready
    serve("seq0", 32'h0, 32'hA000_0000, 1);
    check("seq0_valid", 64'(instr_valid), 64'd1);
    check("seq0_ipc", 64'(instr_pc), 64'h0);
    check("seq0_instr", 64'(instr), 64'hA000_0000);
    serve("seq1", 32'h4, 32'hA000_0004, 1);
    check("seq1_ipc", 64'(instr_pc), 64'h4);
    check("seq1_instr", 64'(instr), 64'hA000_0004);
    serve("seq2", 32'h8, 32'hA000_0008, 1);
    check("seq2_ipc", 64'(instr_pc), 64'h8);
    check("seq2_instr", 64'(instr), 64'hA000_0008);

    // queue fill with decode stalled
    decode_ready = 1'b0;
    do_reset();
    step();
    check("fill_req0", 64'(icache_PC), 64'h0);
    for (int i = 0; i < 4; i++) begin
      icache_instruction = 32'hD000_0000 + 32'(i * 4);
      icache_instrReady  = 1'b1;
      step();
    end
    icache_instrReady = 1'b0;
    check("full_req_low", 64'(icache_instrRequest), 64'd0);
    check("full_head_pc", 64'(instr_pc), 64'h0);
    check("full_head_instr", 64'(instr), 64'hD000_0000);
    step();
    check("full_req_still_low", 64'(icache_instrRequest), 64'd0);
    decode_ready = 1'b1;
    step();
    decode_ready = 1'b0;
    check("pop_req_low", 64'(icache_instrRequest), 64'd0);
    check("pop_head_pc", 64'(instr_pc), 64'h4);
    check("pop_head_instr", 64'(instr), 64'hD000_0004);
    step();
    check("refill_req", 64'(icache_instrRequest), 64'd1);
    check("refill_pc", 64'(icache_PC), 64'h10);

    // asynchronous reset while WAIT with 3 entries queued
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_req", 64'(icache_instrRequest), 64'd0);
    check("async_rst_valid", 64'(instr_valid), 64'd0);
    check("async_rst_pc", 64'(icache_PC), 64'h0);
    check("async_rst_ipc", 64'(instr_pc), 64'h0);
    step();
    rst_n = 1'b1;
    step();
    check("restart_req", 64'(icache_instrRequest), 64'd1);
    check("restart_pc", 64'(icache_PC), 64'h0);

    // redirect with a request in flight, response squashed 3 cycles later
    decode_ready = 1'b1;
    serve("rd0", 32'h0, 32'hB000_0000, 1);
    serve("rd1", 32'h4, 32'hB000_0004, 1);
    check("rd_pre_pc", 64'(icache_PC), 64'h8);
    redirect    = 1'b1;
    redirect_pc = 32'h0000_0103;
    step();
    redirect = 1'b0;
    check("sq_valid", 64'(instr_valid), 64'd0);
    check("sq_req_held", 64'(icache_instrRequest), 64'd1);
    check("sq_pc_held", 64'(icache_PC), 64'h8);
    step();
    check("sq_pc_held2", 64'(icache_PC), 64'h8);
    step();
    icache_instruction = 32'hDEAD_0008;
    icache_instrReady  = 1'b1;
    step();
    icache_instrReady = 1'b0;
    check("sq_discard_valid", 64'(instr_valid), 64'd0);
    check("sq_new_req", 64'(icache_instrRequest), 64'd1);
    check("sq_new_pc", 64'(icache_PC), 64'h100);
    serve("tgt", 32'h100, 32'hC000_0100, 1);
    check("tgt_ipc", 64'(instr_pc), 64'h100);
    check("tgt_instr", 64'(instr), 64'hC000_0100);

    // redirect in the same cycle as ready
    do_reset();
    serve("same0", 32'h0, 32'hE000_0000, 1);
    check("same0_ipc", 64'(instr_pc), 64'h0);
    icache_instruction = 32'hBAD0_0004;
    icache_instrReady  = 1'b1;
    redirect           = 1'b1;
    redirect_pc        = 32'h0000_0200;
    step();
    redirect          = 1'b0;
    icache_instrReady = 1'b0;
    check("same_valid", 64'(instr_valid), 64'd0);
    check("same_req", 64'(icache_instrRequest), 64'd1);
    check("same_pc", 64'(icache_PC), 64'h200);
    step();
    check("same_valid2", 64'(instr_valid), 64'd0);
    serve("same_tgt", 32'h200, 32'hE000_0200, 1);
    check("same_tgt_ipc", 64'(instr_pc), 64'h200);
    check("same_tgt_instr", 64'(instr), 64'hE000_0200);

    // PC wrap on the second instance
    do_reset();
    step();
    check("wrap_req", 64'(w_req), 64'd1);
    check("wrap_first_pc", 64'(w_icache_PC), 64'hFFFF_FFF8);
    w_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      w_icache_instruction = 32'hF000_0000 + 32'(i);
      step();
      check("wrap_ipc", 64'(w_instr_pc), 64'(wrap_pc[i]));
      check("wrap_instr", 64'(w_instr), 64'(32'hF000_0000 + 32'(i)));
      if (i == 1) check("wrap_icache_pc", 64'(w_icache_PC), 64'h0);
    end
    w_ready = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
